freq_meter: RTL and testbench

//  Measures the period of a divided clock (e.g. the freq_div clockout) in clockin cycles.
//  - Optional averaging over 2^AVG_LOG2 periods.
//  - Compares the result against an expected value within a tolerance.

---
 rtl/freq_meter_pkg.sv | 19 +
 rtl/freq_meter_if.sv | 33 +++
 rtl/freq_meter_sync_edge_det.sv | 34 +++
 rtl/freq_meter.sv | 151 +++++++++++++++
 tb/tb_freq_meter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_meter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : freq_meter_pkg                                                   |
// | Brief   : Shared FSM encoding and field widths for the frequency meter.    |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
package freq_meter_pkg;

    localparam int TOL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_MEASURE   = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/freq_meter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : freq_meter_if                                                    |
// | Brief   : Measurement request and result handshake bundle.                 |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface freq_meter_if #(
    parameter int CNT_W = 16
) ();
    import freq_meter_pkg::*;

    logic             sigin;
    logic             start;
    logic [CNT_W-1:0] expected;
    logic [TOL_W-1:0] tolerance;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             period_ready;
    logic             match;
    logic             timeout;
    logic             busy;

    modport master (
        output sigin, start, expected, tolerance, period_ready,
        input  period, period_valid, match, timeout, busy
    );

    modport slave (
        input  sigin, start, expected, tolerance, period_ready,
        output period, period_valid, match, timeout, busy
    );
endinterface
`default_nettype wire

// File: rtl/freq_meter_sync_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sync_edge_det                                                    |
// | Brief   : Multi-flop synchroniser followed by a registered rise pulse.     |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;

    // Pulse lands SYNC_STAGES+1 cycles after the input edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_rise = r_rise;
endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : freq_meter                                                       |
// | Brief   : Period meter with averaging and tolerance compare.               |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int AVG_LOG2    = 0
) (
    input  logic        clockin,
    input  logic        reset,
    freq_meter_if.slave mif
);
    localparam int               ACC_W      = CNT_W + AVG_LOG2;
    localparam int               NPER_W     = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [NPER_W-1:0] c_NPER_TGT = NPER_W'(1) << AVG_LOG2;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic [NPER_W-1:0] r_nper;
    logic [CNT_W-1:0]  r_period;
    logic              r_valid;
    logic              r_match;
    logic              r_timeout;
    logic              r_busy;

    logic              w_rise;
    logic [ACC_W-1:0]  w_acc_next;
    logic [NPER_W-1:0] w_nper_next;
    logic [CNT_W-1:0]  w_avg;
    logic [CNT_W:0]    w_diff;
    logic [CNT_W:0]    w_abs;
    logic              w_match;
    logic              w_xfer;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clockin),
        .rst    (reset),
        .i_sig  (mif.sigin),
        .o_rise (w_rise)
    );

    assign w_acc_next  = r_acc + ACC_W'(r_cnt);
    assign w_nper_next = r_nper + NPER_W'(1);
    assign w_avg       = CNT_W'(w_acc_next >> AVG_LOG2);

    // One extra bit keeps the sign so the magnitude is exact for any operands.
    assign w_diff  = {1'b0, w_avg} - {1'b0, mif.expected};
    assign w_abs   = w_diff[CNT_W] ? (~w_diff + 1'b1) : w_diff;
    assign w_match = (w_abs <= {{(CNT_W+1-TOL_W){1'b0}}, mif.tolerance});
    assign w_xfer  = r_valid & mif.period_ready;

    always_ff @(posedge clockin) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_nper    <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_match   <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mif.start) begin
                        r_state <= ST_WAIT_EDGE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT_EDGE: begin
                    if (w_rise) begin
                        r_state <= ST_MEASURE;
                        r_cnt   <= CNT_W'(1);
                        r_acc   <= '0;
                        r_nper  <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state   <= ST_DONE;
                        r_valid   <= 1'b1;
                        r_period  <= c_CNT_MAX;
                        r_match   <= 1'b0;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        r_acc  <= w_acc_next;
                        r_nper <= w_nper_next;
                        r_cnt  <= CNT_W'(1);
                        if (w_nper_next == c_NPER_TGT) begin
                            r_state   <= ST_DONE;
                            r_valid   <= 1'b1;
                            r_period  <= w_avg;
                            r_match   <= w_match;
                            r_timeout <= 1'b0;
                            r_busy    <= 1'b0;
                        end
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state   <= ST_DONE;
                        r_valid   <= 1'b1;
                        r_period  <= c_CNT_MAX;
                        r_match   <= 1'b0;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // Result is held until accepted; a coincident start re-arms at once.
                    if (w_xfer) begin
                        r_valid   <= 1'b0;
                        r_period  <= '0;
                        r_match   <= 1'b0;
                        r_timeout <= 1'b0;
                        if (mif.start) begin
                            r_state <= ST_WAIT_EDGE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mif.period       = r_period;
    assign mif.period_valid = r_valid;
    assign mif.match        = r_match;
    assign mif.timeout      = r_timeout;
    assign mif.busy         = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_freq_meter                                                    |
// | Brief   : Scoreboard bench for freq_meter (plain, averaging, narrow).      |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_freq_meter;
    typedef struct {
        logic [15:0] period;
        logic        match;
        logic        timeout;
    } exp_t;

    logic clockin = 1'b0;
    logic reset   = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   half_a  = 0;
    int   half_b  = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clockin = ~clockin;

    freq_meter_if #(.CNT_W(16)) if_a ();
    freq_meter_if #(.CNT_W(16)) if_b ();
    freq_meter_if #(.CNT_W(8))  if_c ();

    freq_meter #(.CNT_W(16), .SYNC_STAGES(2), .AVG_LOG2(0)) u_a (
        .clockin (clockin), .reset (reset), .mif (if_a.slave));
    freq_meter #(.CNT_W(16), .SYNC_STAGES(2), .AVG_LOG2(2)) u_b (
        .clockin (clockin), .reset (reset), .mif (if_b.slave));
    freq_meter #(.CNT_W(8),  .SYNC_STAGES(2), .AVG_LOG2(0)) u_c (
        .clockin (clockin), .reset (reset), .mif (if_c.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Square-wave sources: full period = 2*half clockin cycles, half=0 holds low.
    initial begin : g_sig_a
        int k;
        k = 0;
        if_a.sigin = 1'b0;
        forever begin
            @(posedge clockin); #1;
            if (half_a == 0) begin
                if_a.sigin = 1'b0; k = 0;
            end else begin
                k++;
                if (k >= half_a) begin k = 0; if_a.sigin = ~if_a.sigin; end
            end
        end
    end

    initial begin : g_sig_b
        int k;
        k = 0;
        if_b.sigin = 1'b0;
        forever begin
            @(posedge clockin); #1;
            if (half_b == 0) begin
                if_b.sigin = 1'b0; k = 0;
            end else begin
                k++;
                if (k >= half_b) begin k = 0; if_b.sigin = ~if_b.sigin; end
            end
        end
    end

    // Monitors: pop one expectation per accepted result.
    always @(negedge clockin) begin
        if (!reset && if_a.period_valid && if_a.period_ready) begin
            if (q_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL a_spurious: got period %0d, expected no result", if_a.period);
            end else begin : pop_a
                exp_t e;
                e = q_a.pop_front();
                check("a_period",  32'(if_a.period), 32'(e.period));
                check("a_match",   32'(if_a.match), 32'(e.match));
                check("a_timeout", 32'(if_a.timeout), 32'(e.timeout));
            end
        end
    end

    always @(negedge clockin) begin
        if (!reset && if_b.period_valid && if_b.period_ready) begin
            if (q_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL b_spurious: got period %0d, expected no result", if_b.period);
            end else begin : pop_b
                exp_t e;
                e = q_b.pop_front();
                check("b_period",  32'(if_b.period), 32'(e.period));
                check("b_match",   32'(if_b.match), 32'(e.match));
                check("b_timeout", 32'(if_b.timeout), 32'(e.timeout));
            end
        end
    end

    always @(negedge clockin) begin
        if (!reset && if_c.period_valid && if_c.period_ready) begin
            if (q_c.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL c_spurious: got period %0d, expected no result", if_c.period);
            end else begin : pop_c
                exp_t e;
                logic [15:0] p;
                e = q_c.pop_front();
                p = e.period;
                check("c_period",  32'(if_c.period), 32'(p[7:0]));
                check("c_match",   32'(if_c.match), 32'(e.match));
                check("c_timeout", 32'(if_c.timeout), 32'(e.timeout));
            end
        end
    end

    function automatic int qsize(input int which);
        case (which)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    task automatic pulse_start(input int which);
        @(posedge clockin); #1;
        case (which)
            0:       if_a.start = 1'b1;
            1:       if_b.start = 1'b1;
            default: if_c.start = 1'b1;
        endcase
        @(posedge clockin); #1;
        if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
    endtask

    task automatic drain(input int which, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (qsize(which) == 0) break;
            @(negedge clockin);
        end
        check($sformatf("drain_%0d", which), 32'(qsize(which)), 32'd0);
    endtask

    task automatic wait_valid_a(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (if_a.period_valid) break;
            @(negedge clockin);
        end
        check(name, 32'(if_a.period_valid), 32'd1);
    endtask

    task automatic run_a(input logic [15:0] exp_v, input logic [7:0] tol,
                         input logic [15:0] per, input logic m);
        exp_t e;
        if_a.expected  = exp_v;
        if_a.tolerance = tol;
        e.period = per; e.match = m; e.timeout = 1'b0;
        q_a.push_back(e);
        pulse_start(0);
        drain(0, 300);
    endtask

    initial begin : g_watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : g_main
        exp_t e;
        logic prev;
        logic found;
        logic [7:0]  tol_tbl [3];
        logic [15:0] exp_tbl [3];
        logic        m_tbl   [3];

        if_a.start = 1'b0; if_a.expected = '0; if_a.tolerance = '0; if_a.period_ready = 1'b1;
        if_b.start = 1'b0; if_b.expected = '0; if_b.tolerance = '0; if_b.period_ready = 1'b1;
        if_c.start = 1'b0; if_c.expected = '0; if_c.tolerance = '0; if_c.period_ready = 1'b1;
        if_c.sigin = 1'b0;

        repeat (3) @(posedge clockin);
        @(negedge clockin);
        check("rst_a", {if_a.period_valid, if_a.match, if_a.timeout, if_a.busy, if_a.period}, 32'd0);
        check("rst_b", {if_b.period_valid, if_b.match, if_b.timeout, if_b.busy, if_b.period}, 32'd0);
        check("rst_c", {if_c.period_valid, if_c.match, if_c.timeout, if_c.busy, if_c.period}, 32'd0);
        @(posedge clockin); #1;
        reset  = 1'b0;
        half_a = 5;
        half_b = 3;
        repeat (4) @(posedge clockin);

        // Basic measurement, period 10
        run_a(16'd10, 8'd0, 16'd10, 1'b1);

        // Tolerance boundaries on both sides of the expected value
        exp_tbl[0] = 16'd9;  tol_tbl[0] = 8'd1; m_tbl[0] = 1'b1;
        exp_tbl[1] = 16'd11; tol_tbl[1] = 8'd1; m_tbl[1] = 1'b1;
        exp_tbl[2] = 16'd8;  tol_tbl[2] = 8'd1; m_tbl[2] = 1'b0;
        for (int i = 0; i < 3; i++) run_a(exp_tbl[i], tol_tbl[i], 16'd10, m_tbl[i]);

        // Back-pressure: result held, start ignored while DONE
        if_a.period_ready = 1'b0;
        if_a.expected = 16'd10; if_a.tolerance = 8'd0;
        e.period = 16'd10; e.match = 1'b1; e.timeout = 1'b0;
        q_a.push_back(e);
        pulse_start(0);
        wait_valid_a("t4_valid", 300);
        for (int i = 0; i < 20; i++) begin
            @(posedge clockin); #1;
            if_a.start = (i == 5);
            @(negedge clockin);
            check("t4_hold", {if_a.period_valid, if_a.match, if_a.timeout, if_a.period},
                  {13'd0, 1'b1, 1'b1, 1'b0, 16'd10});
        end
        check("t4_busy", 32'(if_a.busy), 32'd0);
        @(posedge clockin); #1;
        if_a.period_ready = 1'b1;
        @(posedge clockin);
        @(negedge clockin);
        check("t4_idle", {if_a.period_valid, if_a.busy}, 32'd0);
        check("t4_drained", 32'(q_a.size()), 32'd0);

        // Reset in the middle of a measurement
        pulse_start(0);
        prev  = if_a.sigin;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clockin); #2;
            if (!prev && if_a.sigin) begin found = 1'b1; break; end
            prev = if_a.sigin;
        end
        check("t5_edge_seen", 32'(found), 32'd1);
        repeat (6) @(posedge clockin);
        @(negedge clockin);
        check("t5_busy_pre", 32'(if_a.busy), 32'd1);
        @(posedge clockin); #1;
        reset = 1'b1;
        @(posedge clockin);
        @(negedge clockin);
        check("t5_rst_out", {if_a.period_valid, if_a.match, if_a.timeout, if_a.busy, if_a.period}, 32'd0);
        @(posedge clockin); #1;
        reset = 1'b0;
        run_a(16'd10, 8'd0, 16'd10, 1'b1);

        // Transfer and re-arm in the same cycle
        if_a.period_ready = 1'b0;
        if_a.expected = 16'd10; if_a.tolerance = 8'd0;
        e.period = 16'd10; e.match = 1'b1; e.timeout = 1'b0;
        q_a.push_back(e);
        pulse_start(0);
        wait_valid_a("t6_valid", 300);
        @(posedge clockin); #1;
        if_a.start = 1'b1;
        if_a.period_ready = 1'b1;
        @(posedge clockin); #1;
        if_a.start = 1'b0;
        @(negedge clockin);
        check("t6_rearm", {if_a.busy, if_a.period_valid}, 32'd2);
        if_a.expected = 16'd12; if_a.tolerance = 8'd1;
        e.period = 16'd10; e.match = 1'b0; e.timeout = 1'b0;
        q_a.push_back(e);
        drain(0, 300);

        // Averaging over 4 periods of 6
        if_b.expected = 16'd6; if_b.tolerance = 8'd0;
        e.period = 16'd6; e.match = 1'b1; e.timeout = 1'b0;
        q_b.push_back(e);
        pulse_start(1);
        drain(1, 400);

        // Narrow counter, input stuck low then stuck high
        e.period = 16'h00FF; e.match = 1'b0; e.timeout = 1'b1;
        q_c.push_back(e);
        pulse_start(2);
        drain(2, 600);
        if_c.sigin = 1'b1;
        repeat (10) @(posedge clockin);
        q_c.push_back(e);
        pulse_start(2);
        drain(2, 600);

        repeat (5) @(posedge clockin);
        check("leftover", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
